// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the push-button digit entry front end:
// FSM states, latched action codes, one-hot cursor constants, button indices
// and small helpers to read/write one digit of the packed 16-bit digit word.
package digit_entry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACT,
        HOLD
    } state_t;

    typedef enum logic [2:0] {
        NONE,
        CLR,
        LEFT,
        RIGHT,
        UP,
        DOWN
    } action_t;

    // One-hot cursor values; digit0 is the leftmost digit in digits[15:12]
    localparam logic [3:0] DIGIT0_SEL = 4'b1000;
    localparam logic [3:0] DIGIT1_SEL = 4'b0100;
    localparam logic [3:0] DIGIT2_SEL = 4'b0010;
    localparam logic [3:0] DIGIT3_SEL = 4'b0001;

    // Bit positions of the buttons inside the packed button vectors
    localparam int BTN_CLR   = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 4;

    // Highest-priority action among simultaneous press pulses
    function automatic action_t pick_action(input logic [4:0] press);
        action_t a;
        a = NONE;
        if (press[BTN_CLR])        a = CLR;
        else if (press[BTN_LEFT])  a = LEFT;
        else if (press[BTN_RIGHT]) a = RIGHT;
        else if (press[BTN_UP])    a = UP;
        else if (press[BTN_DOWN])  a = DOWN;
        return a;
    endfunction

    // Cursor bit j selects nibble j of the digit word
    function automatic logic [3:0] digit_field(input logic [15:0] d, input logic [3:0] sel);
        logic [3:0] v;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            if (sel[j]) v = v | d[4*j +: 4];
        end
        return v;
    endfunction

    function automatic logic [15:0] digit_put(input logic [15:0] d, input logic [3:0] sel,
                                              input logic [3:0] v);
        logic [15:0] r;
        r = d;
        for (int j = 0; j < 4; j++) begin
            if (sel[j]) r[4*j +: 4] = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-button debouncer: two-flop synchronizer, then a stability counter.
// The debounced level flips only after the synchronized input has differed
// from it for DEBOUNCE_CYCLES+1 consecutive samples; a rising flip emits a
// one-cycle press pulse in the same cycle the level goes high.
module btn_debounce
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    // Synchronize, count disagreement run, flip level at the threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CW'(DEBOUNCE_CYCLES)) begin
                    level_reg <= sync2_reg;
                    press_reg <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/digit_entry_ctrl.sv
// Push-button front end for the 4-digit seven-segment driver.
// Five debounced buttons edit four BCD digits through a one-hot cursor.
// Optional macro DIGIT_AUTO_REPEAT_EN: holding up or down alone re-applies
// that action every REPEAT_CYCLES clocks while in HOLD.
module digit_entry_ctrl
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500,
    parameter int MAX_DIGIT       = 9,
    parameter int REPEAT_CYCLES   = 12_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_clear,
    output logic [3:0]  sel_digit,
    output logic [3:0]  digit_value,
    output logic [15:0] digits,
    output logic        edit_pulse
);

    localparam logic [3:0] MAX_V = 4'(MAX_DIGIT);

    // Reject parameter values the datapath cannot represent
    if (DEBOUNCE_CYCLES < 1 || MAX_DIGIT < 1 || MAX_DIGIT > 15 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("digit_entry_ctrl: illegal parameter value");
    end

    logic [4:0] raw;
    logic [4:0] level;
    logic [4:0] press;

    assign raw = {btn_down, btn_up, btn_right, btn_left, btn_clear};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_db
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk   (clk),
                .rst_n (rst_n),
                .btn   (raw[gi]),
                .level (level[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    state_t      state_reg, state_next;
    action_t     act_reg, act_next;
    logic [3:0]  sel_reg, sel_next;
    logic [15:0] digits_reg, digits_next;
    logic [3:0]  value_reg, value_next;
    logic        apply_en;
    action_t     apply_act;
    logic        rep_fire;
    action_t     rep_act;

`ifdef DIGIT_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rep_cnt_reg;
    logic          rep_cond;

    assign rep_cond = (state_reg == HOLD) &&
                      ((level == 5'(1 << BTN_UP)) || (level == 5'(1 << BTN_DOWN)));
    assign rep_fire = rep_cond && (rep_cnt_reg == RW'(REPEAT_CYCLES - 1));
    assign rep_act  = level[BTN_UP] ? UP : DOWN;

    // Hold-time counter; restarts on HOLD entry, on condition loss and after each step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_reg <= '0;
        end else if (!rep_cond || rep_fire) begin
            rep_cnt_reg <= '0;
        end else begin
            rep_cnt_reg <= rep_cnt_reg + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
    assign rep_act  = NONE;
`endif

    // State, latched action and display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            act_reg    <= NONE;
            sel_reg    <= DIGIT0_SEL;
            digits_reg <= '0;
            value_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            act_reg    <= act_next;
            sel_reg    <= sel_next;
            digits_reg <= digits_next;
            value_reg  <= value_next;
        end
    end

    // Next state: latch one action per press, apply it once, wait for full release
    always_comb begin
        state_next = state_reg;
        act_next   = act_reg;
        apply_en   = 1'b0;
        apply_act  = act_reg;
        edit_pulse = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|press) begin
                    act_next   = pick_action(press);
                    state_next = ACT;
                end
            end
            ACT: begin
                apply_en   = 1'b1;
                edit_pulse = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (rep_fire) begin
                    apply_en   = 1'b1;
                    apply_act  = rep_act;
                    edit_pulse = 1'b1;
                end
                if (level == '0) begin
                    act_next   = NONE;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Digit/cursor update; the shown value follows the updated cursor and digits
    always_comb begin
        logic [3:0] cur;
        cur         = digit_field(digits_reg, sel_reg);
        sel_next    = sel_reg;
        digits_next = digits_reg;
        if (apply_en) begin
            case (apply_act)
                CLR: begin
                    digits_next = '0;
                    sel_next    = DIGIT0_SEL;
                end
                LEFT:  sel_next = {sel_reg[2:0], sel_reg[3]};
                RIGHT: sel_next = {sel_reg[0], sel_reg[3:1]};
                UP:    digits_next = digit_put(digits_reg, sel_reg,
                                               (cur >= MAX_V) ? 4'd0 : cur + 4'd1);
                DOWN:  digits_next = digit_put(digits_reg, sel_reg,
                                               (cur == 4'd0) ? MAX_V : cur - 4'd1);
                default: ;
            endcase
        end
        value_next = digit_field(digits_next, sel_next);
    end

    assign sel_digit   = sel_reg;
    assign digits      = digits_reg;
    assign digit_value = value_reg;

endmodule
